alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand/result width in bits, WIDTH >= 4, power of two.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-low reset; reset=0 at a rising edge resets the block.
REQ-004 SHALL have port in_valid, input, 1: operation request valid.
REQ-005 SHALL have port in_ready, output, 1: block accepts request this cycle.
REQ-006 SHALL have port op, input, 3: operation select (REQ-013).
REQ-007 SHALL have ports in0 and in1, input, WIDTH each: operands.
REQ-008 SHALL have port out_valid, output, 1: result valid.
REQ-009 SHALL have port out_ready, input, 1: consumer accepts result this cycle.
REQ-010 SHALL have port out, output, WIDTH: result.
REQ-011 SHALL have ports zero, pos, neg, carry, ovf, output, 1 each: flags for the result on out.

Function
REQ-012 SHALL be a two-stage pipeline: S1 registers op/in0/in1; S2 computes and registers out plus flags; accept-to-out_valid latency exactly 2 cycles when unstalled.
REQ-013 SHALL implement op: 0 ADD in0+in1; 1 SUB in0-in1; 2 AND; 3 OR; 4 XOR; 5 SLT signed (out=1 if in0<in1 signed, else 0); 6 SHL in0 << in1[log2(WIDTH)-1:0]; 7 SHR logical, same shift amount.
REQ-014 SHALL truncate results to WIDTH bits (modulo 2^WIDTH).
REQ-015 SHALL set zero=1 iff out==0.
REQ-016 SHALL set pos=1 iff out!=0 and out[WIDTH-1]==0; neg=1 iff out[WIDTH-1]==1; exactly one of zero/pos/neg is 1 while out_valid=1.
REQ-017 SHALL set carry = carry-out of bit WIDTH-1 for ADD, = 1 iff in0>=in1 unsigned for SUB, = 0 otherwise.
REQ-018 SHALL set ovf = signed overflow for ADD/SUB, 0 for all other ops.
REQ-019 SHALL transfer a request when in_valid=1 and in_ready=1 at a rising edge; a result transfers when out_valid=1 and out_ready=1.
REQ-020 SHALL advance S2 when S2 empty or out_ready=1; SHALL advance S1 into S2 under the same condition.
REQ-021 SHALL drive in_ready=1 iff S1 empty or S1 advances this cycle (combinational on out_ready, no internal cycle penalty).
REQ-022 SHALL sustain one accepted request per cycle while out_ready=1 continuously.
REQ-023 SHALL hold out and all flags stable while out_valid=1 and out_ready=0.
REQ-024 SHALL accept a new request in the same cycle the oldest result leaves when both stages full.
REQ-025 SHALL never drop, duplicate or reorder results; maximum two requests in flight.
REQ-026 SHALL ignore op/in0/in1 when in_valid=0.

Reset
REQ-027 SHALL on reset=0 clear S1 and S2 valid bits: out_valid=0 and in_ready=1 from the following cycle.
REQ-028 SHALL on reset=0 drive out=0 and zero=pos=neg=carry=ovf=0.
REQ-029 SHALL discard all in-flight requests on reset mid-operation; no result emerges after reset deasserts unless newly accepted.
REQ-030 SHALL ignore in_valid during any cycle with reset=0.

Verification (WIDTH=16)
REQ-031 SHALL cover: ADD 0x7FFF+0x0001, out_ready=1 -> 2 cycles later out=0x8000, neg=1, ovf=1, carry=0, zero=0, pos=0.
REQ-032 SHALL cover: SUB 0x0005-0x0005 -> out=0x0000, zero=1, carry=1, ovf=0; SUB 0x0003-0x0005 -> out=0xFFFE, neg=1, carry=0.
REQ-033 SHALL cover: SLT 0xFFFF vs 0x0001 -> out=0x0001, pos=1; SHL 0x0001 by 0x0013 -> out=0x0008; SHR 0x8000 by 4 -> 0x0800.
REQ-034 SHALL cover: out_ready=0, three back-to-back requests -> first two accepted, in_ready=0 on third, out held stable; out_ready=1 -> all three results in order, one per cycle.
REQ-035 SHALL cover: reset=0 for one cycle with two requests in flight -> out_valid=0, out=0, flags 0 next cycle; no stale result afterwards.
REQ-036 SHALL cover: continuous stream of 100 random requests with random out_ready -> every result matches reference model, order preserved.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline with valid/ready handshakes on both sides.
// S1 holds the accepted operands; S2 holds the computed result and its flags.
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             pos,
    output logic             neg,
    output logic             carry,
    output logic             ovf
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             advance;
    logic             accept;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic             slt_c;
    logic             zero_c;
    logic             neg_c;
    logic             pos_c;

    // S2 moves whenever it is empty or being drained; S1 follows it.
    assign advance  = !out_valid || out_ready;
    assign in_ready = !s1_valid || advance;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_b     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
            end
            if (accept) begin
                s1_op <= op_e'(op);
                s1_a  <= in0;
                s1_b  <= in1;
            end
        end
    end

    // Result datapath; carry on SUB is the inverted borrow (in0 >= in1 unsigned).
    assign sum_c  = {1'b0, s1_a} + {1'b0, s1_b};
    assign diff_c = {1'b0, s1_a} - {1'b0, s1_b};
    assign slt_c  = $signed(s1_a) < $signed(s1_b);

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (s1_op)
            OP_ADD: begin
                res_c   = sum_c[MSB:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = (s1_a[MSB] == s1_b[MSB]) && (sum_c[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                res_c   = diff_c[MSB:0];
                carry_c = !diff_c[WIDTH];
                ovf_c   = (s1_a[MSB] != s1_b[MSB]) && (diff_c[MSB] != s1_a[MSB]);
            end
            OP_AND:  res_c = s1_a & s1_b;
            OP_OR:   res_c = s1_a | s1_b;
            OP_XOR:  res_c = s1_a ^ s1_b;
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, slt_c};
            OP_SHL:  res_c = s1_a << s1_b[SHW-1:0];
            OP_SHR:  res_c = s1_a >> s1_b[SHW-1:0];
            default: res_c = '0;
        endcase
    end

    assign zero_c = (res_c == '0);
    assign neg_c  = res_c[MSB];
    assign pos_c  = !zero_c && !neg_c;

    // Result register; payload only reloads when a valid entry arrives from S1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out       <= '0;
            zero      <= 1'b0;
            pos       <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out   <= res_c;
                zero  <= zero_c;
                pos   <= pos_c;
                neg   <= neg_c;
                carry <= carry_c;
                ovf   <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=16): directed corner cases, backpressure, reset
// mid-flight, and a random stream against an arithmetic reference model.
module tb_alu_pipe;

    localparam int unsigned W = 16;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] OR_ = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] SLT = 3'd5;
    localparam logic [2:0] SHL = 3'd6;
    localparam logic [2:0] SHR = 3'd7;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         zero;
    logic         pos;
    logic         neg;
    logic         carry;
    logic         ovf;

    int total;
    int bad;
    // Results accepted but not yet transferred, oldest first: {out,z,p,n,c,v}.
    logic [20:0] q[$];

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .in0       (in0),
        .in1       (in1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .zero      (zero),
        .pos       (pos),
        .neg       (neg),
        .carry     (carry),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [20:0] ref_calc(input logic [2:0] o, input logic [15:0] a,
                                             input logic [15:0] b);
        int ua;
        int ub;
        int sa;
        int sb;
        int r;
        logic [15:0] res;
        logic [3:0] sh;
        logic c;
        logic v;
        logic z;
        logic n;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        sh = b[3:0];
        c = 1'b0;
        v = 1'b0;
        res = 16'h0;
        case (o)
            3'd0: begin
                r = ua + ub;
                res = 16'(r);
                c = (r > 65535);
                v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            3'd1: begin
                r = ua - ub;
                res = 16'(r);
                c = (ua >= ub);
                v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            3'd2: res = a & b;
            3'd3: res = a | b;
            3'd4: res = a ^ b;
            3'd5: res = (sa < sb) ? 16'h1 : 16'h0;
            3'd6: res = 16'(ua * (1 << sh));
            default: res = 16'(ua / (1 << sh));
        endcase
        z = (res == 16'h0);
        n = (res >= 16'h8000);
        return {res, z, !z && !n, n, c, v};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check handshake/result against the model, clock, settle.
    task automatic cycle(input logic rst, input logic iv, input logic [2:0] o,
                         input logic [15:0] a, input logic [15:0] b, input logic ordy,
                         output logic acc);
        logic [20:0] exp;
        reset = rst;
        in_valid = iv;
        op = o;
        in0 = a;
        in1 = b;
        out_ready = ordy;
        #1;
        acc = 1'b0;
        if (rst) begin
            chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || ordy));
            acc = iv && in_ready;
            if (out_valid && ordy) begin
                if (q.size() == 0) begin
                    chk("spurious_result", 32'(out_valid), 32'(0));
                end else begin
                    exp = q.pop_front();
                    chk("result", 32'({out, zero, pos, neg, carry, ovf}), 32'(exp));
                end
            end
            if (acc) q.push_back(ref_calc(o, a, b));
        end
        @(posedge clk);
        #1;
        if (!rst) q.delete();
    endtask

    task automatic directed(input string tag, input logic [2:0] o, input logic [15:0] a,
                            input logic [15:0] b, input logic [20:0] exp);
        logic acc;
        cycle(1'b1, 1'b1, o, a, b, 1'b1, acc);
        chk({tag, "_acc"}, 32'(acc), 32'(1));
        chk({tag, "_lat1"}, 32'(out_valid), 32'(0));
        cycle(1'b1, 1'b0, ADD, 16'h0, 16'h0, 1'b1, acc);
        chk({tag, "_lat2"}, 32'(out_valid), 32'(1));
        chk(tag, 32'({out, zero, pos, neg, carry, ovf}), 32'(exp));
        cycle(1'b1, 1'b0, ADD, 16'h0, 16'h0, 1'b1, acc);
    endtask

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic acc;
        logic ordy;
        logic iv;
        int n;
        int cyc;
        total = 0;
        bad = 0;

        // Reset, with in_valid asserted to show it is ignored.
        cycle(1'b0, 1'b1, ADD, 16'h1234, 16'h1111, 1'b0, acc);
        cycle(1'b0, 1'b1, ADD, 16'h1234, 16'h1111, 1'b0, acc);
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_flags", 32'({out, zero, pos, neg, carry, ovf}), 32'(0));
        cycle(1'b1, 1'b0, ADD, 16'h0, 16'h0, 1'b1, acc);
        chk("rst_no_result", 32'(out_valid), 32'(0));

        // Directed corners: {out, zero, pos, neg, carry, ovf}.
        directed("add_ovf",   ADD, 16'h7FFF, 16'h0001, {16'h8000, 5'b00101});
        directed("sub_zero",  SUB, 16'h0005, 16'h0005, {16'h0000, 5'b10010});
        directed("sub_neg",   SUB, 16'h0003, 16'h0005, {16'hFFFE, 5'b00100});
        directed("slt",       SLT, 16'hFFFF, 16'h0001, {16'h0001, 5'b01000});
        directed("shl",       SHL, 16'h0001, 16'h0013, {16'h0008, 5'b01000});
        directed("shr",       SHR, 16'h8000, 16'h0004, {16'h0800, 5'b01000});
        directed("add_carry", ADD, 16'hFFFF, 16'h0001, {16'h0000, 5'b10010});

        // Backpressure: two accepted, third refused, output held, then in-order drain.
        cycle(1'b1, 1'b1, ADD, 16'h1111, 16'h2222, 1'b0, acc);
        chk("bp_acc1", 32'(acc), 32'(1));
        cycle(1'b1, 1'b1, SUB, 16'h5000, 16'h1000, 1'b0, acc);
        chk("bp_acc2", 32'(acc), 32'(1));
        cycle(1'b1, 1'b1, XOR, 16'hAAAA, 16'h5555, 1'b0, acc);
        chk("bp_third_blocked", 32'(acc), 32'(0));
        repeat (2) begin
            cycle(1'b1, 1'b1, XOR, 16'hAAAA, 16'h5555, 1'b0, acc);
            chk("bp_still_blocked", 32'(acc), 32'(0));
            chk("bp_valid_held", 32'(out_valid), 32'(1));
            chk("bp_out_held", 32'({out, zero, pos, neg, carry, ovf}),
                32'(ref_calc(ADD, 16'h1111, 16'h2222)));
        end
        cycle(1'b1, 1'b1, XOR, 16'hAAAA, 16'h5555, 1'b1, acc);
        chk("bp_acc3", 32'(acc), 32'(1));
        chk("bp_stream2", 32'(out_valid), 32'(1));
        cycle(1'b1, 1'b0, ADD, 16'h0, 16'h0, 1'b1, acc);
        chk("bp_stream3", 32'(out_valid), 32'(1));
        cycle(1'b1, 1'b0, ADD, 16'h0, 16'h0, 1'b1, acc);
        chk("bp_drained", 32'(q.size()), 32'(0));
        chk("bp_idle", 32'(out_valid), 32'(0));

        // Reset with both stages occupied: everything in flight is discarded.
        cycle(1'b1, 1'b1, ADD, 16'h0001, 16'h0001, 1'b0, acc);
        cycle(1'b1, 1'b1, ADD, 16'h0002, 16'h0002, 1'b0, acc);
        chk("mid_full", 32'(out_valid), 32'(1));
        chk("mid_in_ready", 32'(in_ready), 32'(0));
        cycle(1'b0, 1'b1, OR_, 16'hFFFF, 16'hFFFF, 1'b1, acc);
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_out", 32'({out, zero, pos, neg, carry, ovf}), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        repeat (4) cycle(1'b1, 1'b0, ADD, 16'h0, 16'h0, 1'b1, acc);
        chk("mid_no_stale", 32'(out_valid), 32'(0));

        // Random stream of 100 requests with random backpressure.
        n = 0;
        cyc = 0;
        while (n < 100 && cyc < 3000) begin
            iv = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            cycle(1'b1, iv, 3'($urandom), rnd16(), rnd16(), ordy, acc);
            if (acc) n++;
            cyc++;
        end
        chk("rand_accepted", 32'(n), 32'(100));
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            cycle(1'b1, 1'b0, ADD, 16'h0, 16'h0, 1'b1, acc);
            cyc++;
        end
        chk("rand_drained", 32'(q.size()), 32'(0));
        chk("rand_idle", 32'(out_valid), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
